hpm_counter_bank: RTL
=====================

# hpm_counter_bank

Parametrised machine counter bank: `mcycle`, `minstret` and `NUM_HPM` event counters (`mhpmcounter3`…), plus `mcountinhibit` and per-counter event selectors. It sits beside the core CSR file on the idex CSR channel and claims only the counter address range. It adds configurable counter width, software-selectable events, per-counter inhibit and optional overflow interrupts.

## Interface
Parameters:
- `NUM_HPM`, 4 — number of event counters, 0..29; counter *k* is at index 3..`NUM_HPM`+2.
- `CNT_W`, 64 — implemented counter width, 33..64.
- `NUM_EVT`, 8 — width of the event input vector, 1..255.

Ports (clock and reset first):
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `csr_we_i` in 1 — CSR write strobe.
- `csr_addr_i` in 12 — CSR address.
- `csr_wdata_i` in 32 — write data; sampled on the rising edge of `clk`.
- `csr_rdata_o` out 32 — read data; combinational from `csr_addr_i`.
- `csr_hit_o` out 1 — the address belongs to this bank; combinational.
- `retire_i` in 1 — one instruction retired this cycle.
- `evt_i` in `NUM_EVT` — event pulses, active-high, one count per cycle high.
- `ovf_irq_o` out 1 — overflow interrupt request; registered.

## Operation
- **Address map**
  - `mcycle` 0xB00 and high half 0xB80.
  - `minstret` 0xB02 and high half 0xB82.
  - `mhpmcounterk` 0xB00+k and high half 0xB80+k.
  - `mcountinhibit` 0x320.
  - `mhpmeventk` 0x320+k.
  - Unimplemented k in 3..31 (k > `NUM_HPM`+2) and 0xB01/0xB81: `csr_hit_o`=1, read 0, writes ignored.
- **Increment conditions**
  - `mcycle` increments every cycle when `mcountinhibit[0]`=0.
  - `minstret` increments when `retire_i`=1 and `mcountinhibit[2]`=0.
  - Counter k increments when `mcountinhibit[k]`=0, `mhpmeventk[7:0]`=e, 1≤e≤`NUM_EVT`, and `evt_i[e-1]`=1.
  - e=0 or e>`NUM_EVT` means the counter never increments.
- **mcountinhibit**: implemented bits are 0, 2 and 3..`NUM_HPM`+2. Bit 1 and unimplemented bits read 0.
- **Width rules**
  - Counter bits at or above `CNT_W` read 0, and writes to them are dropped.
  - Increment is modulo 2^`CNT_W`.
- **Writes**
  - A low-half write replaces bits [31:0] and a high-half write replaces bits [`CNT_W`-1:32]. The other half is unchanged.
  - A counter written in a cycle does not increment in that cycle; the written value is exact.
- **mhpmevent**: bits [7:0] are the event select. Other bits read 0, except OF (see Configuration).
- **Reset**: all counters 0, `mcountinhibit` 0 (all counting), all `mhpmevent` 0, `ovf_irq_o` 0.

## Timing
- Read has 0-cycle latency. A read in the same cycle as a write returns the pre-write value.
- Write and increment take effect at the next rising edge.
- The next cycle's read shows the new value.
- Setting an inhibit bit stops counting from the edge at which the write lands; that cycle does not count.
- Carry from low to high half is applied in the same edge. Software must use a read-high / read-low / re-read-high sequence.
- Reset mid-count clears everything immediately (asynchronous); counting resumes on the first edge after deassertion.

## Configuration
- Macro `HPM_OVF_IRQ_EN`.
- **Defined:**
  - `mhpmeventk[31]` is a sticky OF bit. It is set when an increment wraps counter k from 2^`CNT_W`-1 to 0.
  - Software writes OF directly. A hardware set in the same cycle as a software write of 0 wins, so OF=1.
  - `ovf_irq_o` is registered: next cycle it equals the OR of all OF bits AND NOT `mcountinhibit[k]`.
- **Not defined:**
  - Bit 31 reads 0 and write is ignored.
  - `ovf_irq_o` is tied 0.
  - Wrap is silent.
- `mcycle` and `minstret` never raise OF in either build.

## Structure
- Package `hpm_pkg` holds:
  - Address constants (base 0xB00, high base 0xB80, inhibit 0x320).
  - The `HPM_EVT_SEL_W`=8 and OF bit-position constants.
- Sub-module `hpm_counter`: one `CNT_W`-bit counter with inc, write-low and write-high strobes, and a wrap output.
- `hpm_counter` is instantiated `NUM_HPM`+2 times; the top holds decode, inhibit, event select, OF and the read mux.

## Test plan
- **Post-reset counting:** reset, idle 10 cycles, `retire_i`=1 on 4 of them.
  - Read 0xB00 → 10 (±read-edge), read 0xB02 → 4.
- **Write-wins:** write 0xB00=0xFFFF_FFFF while counting.
  - Next cycle reads 0xFFFF_FFFF; the cycle after reads 0 with 0xB80 incremented by 1.
- **Event select and inhibit:**
  - Set `mhpmevent3`=2 and pulse `evt_i[1]` 5 cycles → `mhpmcounter3`=5.
  - Set `mcountinhibit[3]`=1 and pulse 5 more → still 5.
  - Set `mhpmevent3`=0 → never counts.
- **Width:** `CNT_W`=40; write 0xB83=0xFFFF_FFFF → reads 0x0000_00FF. Write low 0xFFFF_FFFF, 1 event → counter = 0.
- **Overflow (`HPM_OVF_IRQ_EN`):**
  - Preset counter 4 to all-ones and pulse its event once → OF=1, `ovf_irq_o`=1 one cycle later.
  - Write `mhpmevent4` OF=0 → IRQ drops next cycle.
  - Wrap coincident with clear → OF stays 1.
- **Async reset mid-count:** assert `rst_n`=0 mid-cycle → all counters, OF and `ovf_irq_o` are 0 immediately.

Source files
------------

// File: rtl/hpm_pkg.sv
// Shared constants and CSR address decode for the hardware performance counter bank.
package hpm_pkg;

  localparam logic [11:0] HPM_CNT_BASE     = 12'hB00;
  localparam logic [11:0] HPM_CNT_HI_BASE  = 12'hB80;
  localparam logic [11:0] HPM_INHIBIT_ADDR = 12'h320;

  localparam int HPM_EVT_SEL_W = 8;
  localparam int HPM_OF_BIT    = 31;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CNT_LO,
    REG_CNT_HI,
    REG_INHIBIT,
    REG_EVENT
  } hpm_reg_e;

  typedef struct packed {
    hpm_reg_e   kind;
    logic [4:0] idx;
  } hpm_dec_t;

  // Each claimed window is 32 entries wide, so the upper seven address bits pick the window.
  function automatic hpm_dec_t hpm_decode(logic [11:0] addr);
    hpm_dec_t d;
    d.kind = REG_NONE;
    d.idx  = addr[4:0];
    if (addr[11:5] == HPM_CNT_BASE[11:5]) begin
      d.kind = REG_CNT_LO;
    end else if (addr[11:5] == HPM_CNT_HI_BASE[11:5]) begin
      d.kind = REG_CNT_HI;
    end else if (addr == HPM_INHIBIT_ADDR) begin
      d.kind = REG_INHIBIT;
    end else if ((addr[11:5] == HPM_INHIBIT_ADDR[11:5]) && (addr[4:0] >= 5'd3)) begin
      d.kind = REG_EVENT;
    end
    return d;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One CNT_W-bit counter with split 32-bit write ports; a write always beats the increment.
module hpm_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
    end else if (inc_i) begin
      cnt_d  = cnt_q + CNT_W'(1);
      wrap_o = &cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine counter bank: mcycle, minstret, NUM_HPM event counters, mcountinhibit, mhpmevent.
// Build macro HPM_OVF_IRQ_EN enables the sticky OF bits and the registered overflow interrupt.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int NUM_HPM = 4,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_we_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  output logic               csr_hit_o,
  input  logic               retire_i,
  input  logic [NUM_EVT-1:0] evt_i,
  output logic               ovf_irq_o
);

  localparam int NCNT = NUM_HPM + 2;
  localparam int NEV  = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  // Counter slot 0 is mcycle, slot 1 is minstret, slot i>=2 is mhpmcounter(i+1).
  function automatic logic [4:0] slot_csr(int slot);
    return (slot == 0) ? 5'd0 : 5'(slot + 1);
  endfunction

  hpm_dec_t dec;
  logic     wr_inh;

  logic [31:0]              inh_q, inh_d;
  logic [HPM_EVT_SEL_W-1:0] sel_q [NEV];
  logic [HPM_EVT_SEL_W-1:0] sel_d [NEV];
  logic [NEV-1:0]           wr_ev;
  logic [NEV-1:0]           of_q;

  logic [255:0]     evt_ext;
  logic [NCNT-1:0]  inc, wr_lo, wr_hi, wrap;
  logic [CNT_W-1:0] cnt [NCNT];

  assign dec       = hpm_decode(csr_addr_i);
  assign csr_hit_o = (dec.kind != REG_NONE);
  assign wr_inh    = csr_we_i && (dec.kind == REG_INHIBIT);

  // The new inhibit value already gates the edge at which it is written.
  assign inh_d = wr_inh ? (csr_wdata_i & INH_MASK) : inh_q;

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int i = 0; i < NCNT; i++) begin
      wr_lo[i] = csr_we_i && (dec.kind == REG_CNT_LO) && (dec.idx == slot_csr(i));
      wr_hi[i] = csr_we_i && (dec.kind == REG_CNT_HI) && (dec.idx == slot_csr(i));
    end
  end

  always_comb begin
    wr_ev = '0;
    sel_d = sel_q;
    for (int j = 0; j < NUM_HPM; j++) begin
      wr_ev[j] = csr_we_i && (dec.kind == REG_EVENT) && (dec.idx == 5'(j + 3));
      if (wr_ev[j]) begin
        sel_d[j] = csr_wdata_i[HPM_EVT_SEL_W-1:0];
      end
    end
  end

  // Selector e picks evt_i[e-1]; zero-extending to 256 bits makes e=0 and e>NUM_EVT read 0.
  always_comb begin
    evt_ext = 256'(evt_i);
    inc     = '0;
    inc[0]  = ~inh_d[0];
    inc[1]  = retire_i & ~inh_d[2];
    for (int j = 0; j < NUM_HPM; j++) begin
      inc[j+2] = ~inh_d[j+3] & (sel_q[j] != '0) & evt_ext[sel_q[j] - 8'd1];
    end
  end

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    hpm_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (inc[i]),
      .wr_lo_i (wr_lo[i]),
      .wr_hi_i (wr_hi[i]),
      .wdata_i (csr_wdata_i),
      .cnt_o   (cnt[i]),
      .wrap_o  (wrap[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_q <= '0;
      for (int j = 0; j < NEV; j++) begin
        sel_q[j] <= '0;
      end
    end else begin
      inh_q <= inh_d;
      sel_q <= sel_d;
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NEV-1:0] of_d;
  logic           ovf_irq_q, ovf_irq_d;
  logic           unused_wrap;

  // A hardware wrap overrides a same-cycle software write of OF.
  always_comb begin
    of_d      = of_q;
    ovf_irq_d = 1'b0;
    for (int j = 0; j < NUM_HPM; j++) begin
      if (wr_ev[j]) begin
        of_d[j] = csr_wdata_i[HPM_OF_BIT];
      end
      if (wrap[j+2]) begin
        of_d[j] = 1'b1;
      end
      ovf_irq_d = ovf_irq_d | (of_q[j] & ~inh_q[j+3]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_q      <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      of_q      <= of_d;
      ovf_irq_q <= ovf_irq_d;
    end
  end

  assign ovf_irq_o   = ovf_irq_q;
  assign unused_wrap = ^wrap[1:0];
`else
  logic unused_wrap;

  assign of_q        = '0;
  assign ovf_irq_o   = 1'b0;
  assign unused_wrap = ^{wrap, wr_ev};
`endif

  always_comb begin
    csr_rdata_o = '0;
    case (dec.kind)
      REG_CNT_LO: begin
        for (int i = 0; i < NCNT; i++) begin
          if (dec.idx == slot_csr(i)) csr_rdata_o = cnt[i][31:0];
        end
      end
      REG_CNT_HI: begin
        for (int i = 0; i < NCNT; i++) begin
          if (dec.idx == slot_csr(i)) csr_rdata_o = 32'(cnt[i][CNT_W-1:32]);
        end
      end
      REG_INHIBIT: csr_rdata_o = inh_q;
      REG_EVENT: begin
        for (int j = 0; j < NUM_HPM; j++) begin
          if (dec.idx == 5'(j + 3)) begin
            csr_rdata_o = {of_q[j], {(31 - HPM_EVT_SEL_W){1'b0}}, sel_q[j]};
          end
        end
      end
      default: csr_rdata_o = '0;
    endcase
  end

endmodule
